// File: rtl/lcd_page_scheduler_if.sv
// Character stream from the page scheduler to the LCD character writer.
// master offers ch_data/ch_pos under ch_valid; slave accepts with ch_ready.
interface lcd_page_scheduler_if;
  logic [7:0] ch_data;
  logic [4:0] ch_pos;
  logic       ch_valid;
  logic       ch_ready;

  modport master (
    output ch_data,
    output ch_pos,
    output ch_valid,
    input  ch_ready
  );

  modport slave (
    input  ch_data,
    input  ch_pos,
    input  ch_valid,
    output ch_ready
  );
endinterface

// File: rtl/lcd_page_scheduler.sv
// Snapshots one page of two 16-char strings and streams its 32 characters
// to the LCD writer on refresh ticks, manual page advance or auto-rotation.
module lcd_page_scheduler #(
  parameter int NPAGES      = 4,
  parameter int REFRESH_CYC = 1000000,
  parameter int AUTO_ROT    = 0,
  localparam int PW = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
  input  logic                   GCLK,
  input  logic                   RST,
  input  logic                   page_next,
  input  logic [NPAGES*256-1:0]  str_bus,
  lcd_page_scheduler_if.master   ch,
  output logic                   frame_done,
  output logic [PW-1:0]          page
);

  localparam int RW = $clog2(REFRESH_CYC);
  localparam int FW = (AUTO_ROT > 1) ? $clog2(AUTO_ROT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    SEND,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic           pend_q, pend_d;
  logic [RW-1:0]  rc_q, rc_d;
  logic [FW-1:0]  fc_q, fc_d;
  logic [PW-1:0]  page_q, page_d;
  logic [255:0]   snap_q, snap_d;
  logic [4:0]     idx_q, idx_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;

  logic           tick;
  logic           auto_adv;
  logic           adv;
  logic [PW-1:0]  page_inc;
  logic [255:0]   sel;

  always_comb begin
    sel = '0;
    for (int p = 0; p < NPAGES; p++) begin
      if (page_q == PW'(p)) sel = str_bus[256*p +: 256];
    end
  end

  assign page_inc = (page_q == PW'(NPAGES - 1)) ? '0 : page_q + PW'(1);

  always_comb begin
    tick = (rc_q == RW'(REFRESH_CYC - 1));
    rc_d = tick ? '0 : rc_q + RW'(1);
  end

  // frame_done pulses are counted; reaching AUTO_ROT behaves like page_next
  always_comb begin
    fc_d     = fc_q;
    auto_adv = 1'b0;
    if (AUTO_ROT > 0 && done_q) begin
      if (fc_q == FW'(AUTO_ROT - 1)) begin
        fc_d     = '0;
        auto_adv = 1'b1;
      end else begin
        fc_d = fc_q + FW'(1);
      end
    end
  end

  assign adv    = page_next | auto_adv;
  assign page_d = adv ? page_inc : page_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | tick | adv;
    snap_d  = snap_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = LATCH;
          pend_d  = tick | adv;
        end
      end
      LATCH: begin
        snap_d  = sel;
        idx_d   = '0;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        // snapshot shifts left so the offered char is always the top byte
        if (ch.ch_ready) begin
          snap_d = {snap_q[247:0], 8'h00};
          idx_d  = idx_q + 5'd1;
          if (idx_q == 5'd31) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge GCLK) begin
    if (RST) begin
      state_q <= IDLE;
      pend_q  <= 1'b1;
      rc_q    <= '0;
      fc_q    <= '0;
      page_q  <= '0;
      snap_q  <= {8'h20, 248'h0};
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rc_q    <= rc_d;
      fc_q    <= fc_d;
      page_q  <= page_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign ch.ch_data  = snap_q[255:248];
  assign ch.ch_pos   = idx_q;
  assign ch.ch_valid = valid_q;
  assign frame_done  = done_q;
  assign page        = page_q;

endmodule
